// File: rtl/tank_access_ctrl.sv
// tank_access_ctrl: word-level read/write access to a serial recirculating delay-line tank.
// Define TANK_ACCESS_VERIFY_EN to add a read-back check one revolution after every write.
module tank_access_ctrl #(
    parameter int STORE_LEN  = 32,
    parameter int WORD_WIDTH = 18,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  dl_data_in,
    output logic                  dl_data_in_gate,
    output logic                  dl_data_clr,
    input  logic                  dl_data_out
);
    localparam int BCW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int WCW = (STORE_LEN > 1) ? $clog2(STORE_LEN) : 1;
    localparam logic [BCW-1:0] BIT_LAST    = BCW'(WORD_WIDTH - 1);
    localparam logic [WCW-1:0] WORD_LAST   = WCW'(STORE_LEN - 1);
    localparam logic [31:0]    STORE_LEN_U = 32'(STORE_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEEK,
        S_XFER,
`ifdef TANK_ACCESS_VERIFY_EN
        S_VERIFY,
`endif
        S_RESP
    } state_t;

    state_t                state_q;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WCW-1:0]        word_cnt_q, word_cnt_d;
    logic                  bit_last;
    logic                  write_q;
    logic [WCW-1:0]        addr_q;
    logic [WORD_WIDTH-1:0] wdata_q;
    logic [WORD_WIDTH-1:0] rd_shift_q, rd_word;
    logic                  rsp_valid_q, rsp_err_q;
    logic [WORD_WIDTH-1:0] rsp_rdata_q;
    logic                  dl_in_q, dl_gate_q, dl_clr_q;
    logic [31:0]           addr_ext;
    logic                  addr_ok;
`ifdef TANK_ACCESS_VERIFY_EN
    logic [WORD_WIDTH-1:0] vfy_shift_q, vfy_word;
`endif

    always_comb begin
        bit_last   = (bit_cnt_q == BIT_LAST);
        bit_cnt_d  = bit_last ? '0 : bit_cnt_q + BCW'(1);
        word_cnt_d = word_cnt_q;
        if (bit_last) begin
            word_cnt_d = (word_cnt_q == WORD_LAST) ? '0 : word_cnt_q + WCW'(1);
        end
        addr_ext = 32'(req_addr);
        addr_ok  = (addr_ext < STORE_LEN_U);
        // Assembled word including the bit emerging this cycle (LSB first).
        rd_word            = rd_shift_q;
        rd_word[bit_cnt_q] = dl_data_out;
`ifdef TANK_ACCESS_VERIFY_EN
        vfy_word            = vfy_shift_q;
        vfy_word[bit_cnt_q] = dl_data_out;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            dl_in_q     <= 1'b0;
            dl_gate_q   <= 1'b0;
            dl_clr_q    <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
            rsp_valid_q <= 1'b0;
            dl_in_q     <= 1'b0;
            dl_gate_q   <= 1'b0;
            dl_clr_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        addr_q  <= WCW'(addr_ext);
                        wdata_q <= req_wdata;
                        if (addr_ok) begin
                            state_q <= S_SEEK;
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= '0;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                // Line drive is registered, so it is set up one cycle before the bit it targets.
                S_SEEK: begin
                    if (bit_last && (word_cnt_d == addr_q)) begin
                        state_q   <= S_XFER;
                        dl_gate_q <= write_q;
                        dl_clr_q  <= write_q;
                        dl_in_q   <= write_q & wdata_q[0];
                    end
                end
                S_XFER: begin
                    rd_shift_q <= rd_word;
                    if (!bit_last) begin
                        dl_gate_q <= write_q;
                        dl_clr_q  <= write_q;
                        dl_in_q   <= write_q & wdata_q[bit_cnt_d];
                    end
`ifdef TANK_ACCESS_VERIFY_EN
                    else if (write_q) begin
                        state_q <= S_VERIFY;
                    end
`endif
                    else begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rd_word;
                        rsp_err_q   <= 1'b0;
                    end
                end
`ifdef TANK_ACCESS_VERIFY_EN
                // The target word next comes round exactly one revolution after the write.
                S_VERIFY: begin
                    if (word_cnt_q == addr_q) begin
                        vfy_shift_q <= vfy_word;
                        if (bit_last) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rd_shift_q;
                            rsp_err_q   <= (vfy_word != wdata_q);
                        end
                    end
                end
`endif
                S_RESP: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Ready must drop in the very cycle rst is high, so it is gated combinationally.
    assign req_ready       = (state_q == S_IDLE) && !rst;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign dl_data_in      = dl_in_q;
    assign dl_data_in_gate = dl_gate_q;
    assign dl_data_clr     = dl_clr_q;

endmodule

// File: tb/tb_tank_access_ctrl.sv
// Bench for tank_access_ctrl: a 576-bit ring models the delay line; a word array models the tank.
`timescale 1ns/1ps
module tb_tank_access_ctrl;
  localparam int SL  = 32;
  localparam int WW  = 18;
  localparam int AW  = 5;
  localparam int REV = SL * WW;
`ifdef TANK_ACCESS_VERIFY_EN
  localparam int VFY = 1;
`else
  localparam int VFY = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [WW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, dl_in, dl_gate, dl_clr, dl_out;
  logic [WW-1:0] rsp_rdata;

  logic r2_valid = 1'b0;
  logic [AW-1:0] r2_addr = '0;
  logic r2_zero = 1'b0;
  logic [WW-1:0] r2_wdata = '0;
  logic r2_ready, r2_rsp_valid, r2_err, r2_in, r2_gate, r2_clr;
  logic [WW-1:0] r2_rdata;

  tank_access_ctrl #(.STORE_LEN(SL), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dl_data_in(dl_in), .dl_data_in_gate(dl_gate), .dl_data_clr(dl_clr),
    .dl_data_out(dl_out));

  tank_access_ctrl #(.STORE_LEN(20), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) dut20 (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_write(r2_zero), .req_addr(r2_addr), .req_wdata(r2_wdata),
    .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rdata), .rsp_err(r2_err),
    .dl_data_in(r2_in), .dl_data_in_gate(r2_gate), .dl_data_clr(r2_clr),
    .dl_data_out(r2_zero));

  always #5 clk = ~clk;

  // Delay-line environment: position = cycles since reset release, modulo one revolution.
  bit ring [REV];
  int cyc = 0;
  int pos;
  bit stuck_en = 1'b0;
  logic poke_go = 1'b0;
  int poke_word = 0;
  logic [WW-1:0] poke_val = '0;

  always_comb pos = cyc % REV;
  always_comb dl_out = (stuck_en && pos == 9*WW + 7) ? 1'b0 : ring[pos];

  always @(posedge clk) begin
    if (poke_go) begin
      for (int b = 0; b < WW; b++) ring[poke_word*WW + b] <= poke_val[b];
    end else if (dl_gate) begin
      ring[pos] <= dl_in;
    end else if (dl_clr) begin
      ring[pos] <= 1'b0;
    end
    cyc <= rst ? 0 : cyc + 1;
  end

  logic [WW-1:0] mem [SL];
  int checks = 0;
  int passes = 0;

  // First cycle at/after acc+2 where the line presents word addr, bit 0.
  function automatic int first_xfer(input int acc, input int addr);
    return acc + 2 + (((addr*WW - (acc + 2)) % REV) + REV) % REV;
  endfunction

  function automatic int exp_rsp(input int acc, input int addr, input bit wr);
    return first_xfer(acc, addr) + WW + ((VFY != 0 && wr) ? REV : 0);
  endfunction

  task automatic poke(input int w, input logic [WW-1:0] v);
    @(negedge clk);
    poke_go = 1'b1; poke_word = w; poke_val = v;
    @(negedge clk);
    poke_go = 1'b0;
    mem[w] = v;
  endtask

  task automatic run_txn(input bit wr, input int addr, input logic [WW-1:0] wd,
                         output logic [WW-1:0] rd, output logic er,
                         output int acc, output int rsp_at, output int dl_bad);
    int t0, c, n;
    bit eg, ei;
    req_valid = 1'b1; req_write = wr; req_addr = AW'(addr); req_wdata = wd;
    #1;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); #1; n++; end
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    t0 = first_xfer(acc, addr);
    dl_bad = 0; rsp_at = -1; rd = 'x; er = 1'bx;
    for (int k = 0; k < 2*REV + 100; k++) begin
      c  = cyc;
      eg = wr && c >= t0 && c < t0 + WW;
      ei = 1'b0;
      if (eg) ei = wd[c - t0];
      if ({dl_gate, dl_clr, dl_in} !== {eg, eg, ei}) dl_bad++;
      if (rsp_valid === 1'b1) begin rsp_at = c; rd = rsp_rdata; er = rsp_err; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int w = 0; w < SL; w++) poke(w, WW'($urandom));
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passes++;
    checks++; if (rsp_rdata !== '0) $display("FAIL reset_rdata: got %h want 0", rsp_rdata); else passes++;
    checks++; if (rsp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", rsp_err); else passes++;
    checks++; if ({dl_gate, dl_clr, dl_in} !== 3'b000) $display("FAIL reset_dl: got %b want 000", {dl_gate, dl_clr, dl_in}); else passes++;
    checks++; if ({r2_ready, r2_rsp_valid, r2_err, r2_gate, r2_clr, r2_in, r2_rdata} !== '0)
      $display("FAIL reset_dut20: got %h want 0", {r2_ready, r2_rsp_valid, r2_err, r2_gate, r2_clr, r2_in, r2_rdata}); else passes++;
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", req_ready); else passes++;
  endtask

  task automatic test_first_read();
    logic [WW-1:0] rd; logic er; int acc, rat, bad;
    run_txn(1'b0, 0, '0, rd, er, acc, rat, bad);
    checks++; if (rat !== 594) $display("FAIL first_read_latency: got %0d want 594", rat); else passes++;
    checks++; if (rd !== mem[0]) $display("FAIL first_read_data: got %h want %h", rd, mem[0]); else passes++;
    checks++; if (er !== 1'b0) $display("FAIL first_read_err: got %b want 0", er); else passes++;
    checks++; if (bad !== 0) $display("FAIL first_read_dl: got %0d bad cycles want 0", bad); else passes++;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== rd)
      $display("FAIL first_read_hold: got valid=%b data=%h want valid=0 data=%h", rsp_valid, rsp_rdata, rd); else passes++;
  endtask

  task automatic test_write_read();
    logic [WW-1:0] rd, old; logic er; int acc, rat, bad;
    old = mem[5];
    run_txn(1'b1, 5, 18'h2AAAA, rd, er, acc, rat, bad);
    checks++; if (rd !== old || er !== 1'b0) $display("FAIL wr5_rsp: got %h/%b want %h/0", rd, er, old); else passes++;
    checks++; if (rat !== exp_rsp(acc, 5, 1'b1)) $display("FAIL wr5_latency: got %0d want %0d", rat, exp_rsp(acc, 5, 1'b1)); else passes++;
    checks++; if (bad !== 0) $display("FAIL wr5_dl: got %0d bad cycles want 0", bad); else passes++;
    mem[5] = 18'h2AAAA;
    @(negedge clk);
    run_txn(1'b0, 5, '0, rd, er, acc, rat, bad);
    checks++; if (rd !== 18'h2AAAA || er !== 1'b0) $display("FAIL rd5_rsp: got %h/%b want 2aaaa/0", rd, er); else passes++;
  endtask

  task automatic test_neighbours();
    logic [WW-1:0] rd, exp_w; logic er; int acc, rat, bad;
    int order [3];
    order = '{3, 2, 4};
    poke(3, 18'h3FFFF);
    run_txn(1'b1, 3, 18'h00001, rd, er, acc, rat, bad);
    checks++; if (rd !== 18'h3FFFF || er !== 1'b0) $display("FAIL wr3_rsp: got %h/%b want 3ffff/0", rd, er); else passes++;
    mem[3] = 18'h00001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_w = mem[order[i]];
      run_txn(1'b0, order[i], '0, rd, er, acc, rat, bad);
      checks++; if (rd !== exp_w || er !== 1'b0 || bad !== 0)
        $display("FAIL nb_read_%0d: got %h/%b/%0d want %h/0/0", order[i], rd, er, bad, exp_w); else passes++;
    end
  endtask

  task automatic test_latency_corners();
    logic [WW-1:0] rd; logic er; int acc, rat, bad, n, tgt;
    int ca [3]; int co [3]; int cl [3];
    ca = '{10, 10, 0}; co = '{1, 2, 1}; cl = '{REV + WW + 1, WW + 2, REV + WW + 1};
    for (int i = 0; i < 3; i++) begin
      tgt = (ca[i]*WW - co[i] + REV) % REV;
      n = 0;
      while ((cyc % REV) != tgt && n < 2*REV) begin @(negedge clk); n++; end
      run_txn(1'b0, ca[i], '0, rd, er, acc, rat, bad);
      checks++; if (rat - acc !== cl[i] || rd !== mem[ca[i]])
        $display("FAIL corner_%0d: got lat=%0d data=%h want lat=%0d data=%h", i, rat - acc, rd, cl[i], mem[ca[i]]); else passes++;
    end
  endtask

  task automatic test_random();
    logic [WW-1:0] rd, wd, exp_w; logic er; bit wr; int a, acc, rat, bad;
    for (int i = 0; i < 16; i++) begin
      wr = 1'($urandom_range(0, 1)); a = $urandom_range(0, SL-1); wd = WW'($urandom);
      repeat ($urandom_range(0, 40)) @(negedge clk);
      exp_w = mem[a];
      run_txn(wr, a, wd, rd, er, acc, rat, bad);
      checks++; if (rd !== exp_w || er !== 1'b0)
        $display("FAIL rand_%0d_rsp: got %h/%b want %h/0 (wr=%b addr=%0d)", i, rd, er, exp_w, wr, a); else passes++;
      checks++; if (rat !== exp_rsp(acc, a, wr) || bad !== 0)
        $display("FAIL rand_%0d_timing: got at=%0d dlbad=%0d want at=%0d dlbad=0", i, rat, bad, exp_rsp(acc, a, wr)); else passes++;
      if (wr) mem[a] = wd;
    end
  endtask

  task automatic test_out_of_range();
    int oor [2]; int n; bit busy;
    oor = '{25, 20};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      r2_valid = 1'b1; r2_addr = AW'(oor[i]);
      #1;
      checks++; if (r2_ready !== 1'b1) $display("FAIL oor_%0d_ready: got %b want 1", oor[i], r2_ready); else passes++;
      @(posedge clk);
      @(negedge clk);
      r2_valid = 1'b0;
      checks++; if (r2_rsp_valid !== 1'b1 || r2_err !== 1'b1 || r2_rdata !== '0)
        $display("FAIL oor_%0d_rsp: got %b/%b/%h want 1/1/0", oor[i], r2_rsp_valid, r2_err, r2_rdata); else passes++;
      checks++; if ({r2_gate, r2_clr, r2_in} !== 3'b000) $display("FAIL oor_%0d_dl: got %b want 000", oor[i], {r2_gate, r2_clr, r2_in}); else passes++;
      @(negedge clk);
      checks++; if (r2_rsp_valid !== 1'b0 || r2_err !== 1'b1 || r2_ready !== 1'b1)
        $display("FAIL oor_%0d_after: got valid=%b err=%b ready=%b want 0/1/1", oor[i], r2_rsp_valid, r2_err, r2_ready); else passes++;
    end
    r2_valid = 1'b1; r2_addr = AW'(19);
    @(posedge clk);
    @(negedge clk);
    r2_valid = 1'b0;
    n = 0; busy = 1'b0;
    while (r2_rsp_valid !== 1'b1 && n < 400) begin busy |= (r2_gate | r2_clr | r2_in); @(negedge clk); n++; end
    checks++; if (r2_rsp_valid !== 1'b1 || r2_err !== 1'b0 || r2_rdata !== '0 || busy)
      $display("FAIL last_valid_addr: got valid=%b err=%b data=%h dl=%b want 1/0/0/0", r2_rsp_valid, r2_err, r2_rdata, busy); else passes++;
  endtask

  task automatic test_rst_abort();
    logic [WW-1:0] rd; logic er; int acc, rat, bad, n; bit seen;
    n = 0;
    while ((cyc % REV) != 7*WW - 6 && n < 2*REV) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(7); req_wdata = WW'($urandom);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (dl_gate !== 1'b1) $display("FAIL abort_gate_before: got %b want 1", dl_gate); else passes++;
    rst = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    checks++; if ({dl_gate, dl_clr, dl_in} !== 3'b000) $display("FAIL abort_dl_after: got %b want 000", {dl_gate, dl_clr, dl_in}); else passes++;
    repeat (2) begin seen |= (rsp_valid === 1'b1); @(negedge clk); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) $display("FAIL abort_release_ready: got %b want 1", req_ready); else passes++;
    for (int i = 0; i < 40; i++) begin seen |= (rsp_valid === 1'b1); @(negedge clk); end
    checks++; if (seen !== 1'b0) $display("FAIL abort_no_rsp: got rsp_valid seen=%b want 0", seen); else passes++;
    for (int b = 0; b < WW; b++) mem[7][b] = ring[7*WW + b];
    run_txn(1'b0, 7, '0, rd, er, acc, rat, bad);
    checks++; if (rd !== mem[7] || er !== 1'b0) $display("FAIL abort_reread: got %h/%b want %h/0", rd, er, mem[7]); else passes++;
  endtask

`ifdef TANK_ACCESS_VERIFY_EN
  task automatic test_verify();
    logic [WW-1:0] rd, old; logic er; int acc, rat, bad;
    old = mem[9] & ~(18'h1 << 7);
    stuck_en = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 9, 18'h000FF, rd, er, acc, rat, bad);
    checks++; if (er !== 1'b1 || rd !== old) $display("FAIL verify_rsp: got %h/%b want %h/1", rd, er, old); else passes++;
    checks++; if (rat - first_xfer(acc, 9) !== WW + REV) $display("FAIL verify_latency: got %0d want %0d", rat - first_xfer(acc, 9), WW + REV); else passes++;
    stuck_en = 1'b0;
    mem[9] = 18'h000FF;
  endtask
`endif

  initial begin
    test_reset();
    test_first_read();
    test_write_read();
    test_neighbours();
    test_latency_corners();
    test_random();
    test_out_of_range();
    test_rst_abort();
`ifdef TANK_ACCESS_VERIFY_EN
    test_verify();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit after %0d checks", checks);
    $fatal(1, "watchdog");
  end
endmodule
